// File: rtl/mlp_stream_pkg.sv
// Shared constants and FSM encoding for the MLP parameter streamer.
// The job layout matches the axi_mlp_v1_0 S_AXIS consumption order.
package mlp_stream_pkg;

    localparam int IMG_LEN   = 784;
    localparam int HID_N     = 30;
    localparam int OUT_N     = 10;
    localparam int WORD_W    = 18;
    localparam int JOB_WORDS = IMG_LEN + HID_N * (IMG_LEN + 1) + OUT_N * (HID_N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IMG,
        S_W1,
        S_B1,
        S_W2,
        S_B2,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/mlp_stream_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers; count is exported so the
// producer can budget reads against the remaining space.
module mlp_stream_fifo #(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/mlp_param_streamer.sv
// Streams one MLP job (pixels, hidden W/b, output W/b) from parameter BRAM to AXI-Stream.
// Optional macro MLP_STREAMER_TLAST_EN marks pixel 783 and every bias word with tlast.
module mlp_param_streamer
    import mlp_stream_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int NUM_IMAGES = 100,
    parameter int IMG_BASE   = 0,
    parameter int W1_BASE    = 78400,
    parameter int B1_BASE    = 101920,
    parameter int W2_BASE    = 101950,
    parameter int B2_BASE    = 102250,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        img_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       m_axis_tdata,
    output logic [3:0]        m_axis_tstrb,
    output logic              m_axis_tlast
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef MLP_STREAMER_TLAST_EN
    localparam int FIFO_W = WORD_W + 1;
`else
    localparam int FIFO_W = WORD_W;
`endif

    state_t            state, state_next;
    logic [9:0]        i_cnt, i_next;
    logic [4:0]        n_cnt, n_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [ADDR_W-1:0] bptr, bptr_next;
    logic [ADDR_W-1:0] img_base_addr;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue, reject, done_next;
    logic              credit_ok;
    logic [CNT_W:0]    credit_used;
    logic              vld_p1;

    logic              fifo_pop;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;

    assign img_base_addr = ADDR_W'(IMG_BASE) + ADDR_W'(img_idx) * ADDR_W'(IMG_LEN);

    // Reads still in the BRAM pipeline already own a FIFO slot.
    assign credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(mem_en) + (CNT_W + 1)'(vld_p1);
    assign credit_ok   = credit_used < (CNT_W + 1)'(FIFO_DEPTH);

    always_comb begin
        state_next = state;
        i_next     = i_cnt;
        n_next     = n_cnt;
        ptr_next   = ptr;
        bptr_next  = bptr;
        issue      = 1'b0;
        issue_addr = ptr;
        reject     = 1'b0;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !done) begin
                    if (int'(img_idx) >= NUM_IMAGES) begin
                        reject = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = img_base_addr;
                        ptr_next   = img_base_addr + ADDR_W'(1);
                        bptr_next  = ADDR_W'(B1_BASE);
                        i_next     = 10'd1;
                        n_next     = '0;
                        state_next = S_IMG;
                    end
                end
            end
            S_IMG: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    ptr_next = ptr + ADDR_W'(1);
                    if (i_cnt == 10'(IMG_LEN - 1)) begin
                        i_next     = '0;
                        ptr_next   = ADDR_W'(W1_BASE);
                        state_next = S_W1;
                    end else begin
                        i_next = i_cnt + 10'd1;
                    end
                end
            end
            S_W1: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    ptr_next = ptr + ADDR_W'(1);
                    if (i_cnt == 10'(IMG_LEN - 1)) begin
                        i_next     = '0;
                        state_next = S_B1;
                    end else begin
                        i_next = i_cnt + 10'd1;
                    end
                end
            end
            S_B1: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    issue_addr = bptr;
                    bptr_next  = bptr + ADDR_W'(1);
                    if (n_cnt == 5'(HID_N - 1)) begin
                        n_next     = '0;
                        ptr_next   = ADDR_W'(W2_BASE);
                        bptr_next  = ADDR_W'(B2_BASE);
                        state_next = S_W2;
                    end else begin
                        n_next     = n_cnt + 5'd1;
                        state_next = S_W1;
                    end
                end
            end
            S_W2: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    ptr_next = ptr + ADDR_W'(1);
                    if (i_cnt == 10'(HID_N - 1)) begin
                        i_next     = '0;
                        state_next = S_B2;
                    end else begin
                        i_next = i_cnt + 10'd1;
                    end
                end
            end
            S_B2: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    issue_addr = bptr;
                    bptr_next  = bptr + ADDR_W'(1);
                    if (n_cnt == 5'(OUT_N - 1)) begin
                        n_next     = '0;
                        state_next = S_DRAIN;
                    end else begin
                        n_next     = n_cnt + 5'd1;
                        state_next = S_W2;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !mem_en && !vld_p1) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Stage p0: address register; stage p1: BRAM data valid on mem_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            i_cnt    <= '0;
            n_cnt    <= '0;
            ptr      <= '0;
            bptr     <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            vld_p1   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state  <= state_next;
            i_cnt  <= i_next;
            n_cnt  <= n_next;
            ptr    <= ptr_next;
            bptr   <= bptr_next;
            mem_en <= issue;
            if (issue) begin
                mem_addr <= issue_addr;
            end
            vld_p1 <= mem_en;
            done   <= done_next;
            err    <= reject;
        end
    end

`ifdef MLP_STREAMER_TLAST_EN
    logic last_issue, last_p0, last_p1;

    assign last_issue = ((state == S_IMG) && (i_cnt == 10'(IMG_LEN - 1)))
                        || (state == S_B1) || (state == S_B2);

    always_ff @(posedge clk) begin
        last_p0 <= last_issue;
        last_p1 <= last_p0;
    end

    assign fifo_din     = {last_p1, mem_rdata};
    assign m_axis_tlast = m_axis_tvalid && fifo_dout[WORD_W];
`else
    assign fifo_din     = mem_rdata;
    assign m_axis_tlast = 1'b0;
`endif

    mlp_stream_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (vld_p1),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign fifo_pop      = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = m_axis_tvalid ? {14'd0, fifo_dout[WORD_W-1:0]} : 32'd0;
    assign m_axis_tstrb  = m_axis_tvalid ? 4'b1111 : 4'b0000;
    assign busy          = (state != S_IDLE) || done;

endmodule

// File: tb/tb_mlp_param_streamer.sv
// Scoreboard bench for mlp_param_streamer: BRAM model, expected word queues, AXIS monitor.
// Honours MLP_STREAMER_TLAST_EN for the expected tlast pattern.
module tb_mlp_param_streamer;

    localparam int FIFO_DEPTH = 4;
    localparam int JOB_LEN    = 24644;
`ifdef MLP_STREAMER_TLAST_EN
    localparam int EXP_LASTS = 41;
`else
    localparam int EXP_LASTS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  img_idx = 7'd0;
    logic        busy, done, err, mem_en;
    logic [16:0] mem_addr;
    logic [17:0] mem_rdata = 18'd0;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs = 0;
    int issued = 0;
    int last_cnt = 0;
    int mode = 0;
    int start_cyc = 0;

    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic        exp_last_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    mlp_param_streamer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .img_idx       (img_idx),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tstrb  (tstrb),
        .m_axis_tlast  (tlast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [17:0] bram_word(input int a);
        return 18'((a * 7919) ^ (a >> 4) ^ 32'h15A5A);
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= bram_word(int'(mem_addr));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input int addr, input logic last);
        exp_addr_q.push_back(addr);
        exp_data_q.push_back({14'd0, bram_word(addr)});
`ifdef MLP_STREAMER_TLAST_EN
        exp_last_q.push_back(last);
`else
        exp_last_q.push_back(1'b0);
`endif
    endtask

    task automatic build_job(input int img);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
        hs = 0;
        issued = 0;
        last_cnt = 0;
        for (int p = 0; p < 784; p++) push_word(img * 784 + p, p == 783);
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 784; i++) push_word(78400 + n * 784 + i, 1'b0);
            push_word(101920 + n, 1'b1);
        end
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < 30; i++) push_word(101950 + n * 30 + i, 1'b0);
            push_word(102250 + n, 1'b1);
        end
    endtask

    task automatic wait_hs(input int target, input int limit);
        int k = 0;
        while (hs < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("wait_handshakes", hs >= target, 1);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
    endtask

    // AXIS sink and scoreboard: drives tready, checks reads and handshakes at each negedge.
    initial begin
        forever begin
            @(negedge clk);
            case (mode)
                0:       tready = 1'b1;
                1:       tready = ($urandom_range(0, 9) < 3);
                default: tready = 1'b0;
            endcase
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", tvalid, 1);
                    check("stall_data", tdata, prev_data);
                    check("stall_last", tlast, prev_last);
                end
                if (mem_en) begin
                    issued++;
                    check("read_expected", exp_addr_q.size() != 0, 1);
                    if (exp_addr_q.size() != 0) check("mem_addr", mem_addr, exp_addr_q.pop_front());
                end
                if (tvalid && tready) begin
                    check("word_expected", exp_data_q.size() != 0, 1);
                    if (exp_data_q.size() != 0) begin
                        check("tdata", tdata, exp_data_q.pop_front());
                        check("tlast", tlast, exp_last_q.pop_front());
                    end
                    check("tstrb", tstrb, 4'hF);
                    if (hs == 784)  check("w1_first", tdata, {14'd0, bram_word(78400)});
                    if (hs == 1568) check("b1_first", tdata, {14'd0, bram_word(101920)});
                    if (tlast) last_cnt++;
                    hs++;
                end
                check("occupancy", (issued - hs) <= FIFO_DEPTH, 1);
                prev_stall = tvalid && !tready;
                prev_data  = tdata;
                prev_last  = tlast;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tstrb", tstrb, 0);
        check("rst_tlast", tlast, 0);
        reset = 1'b0;

        // Image 0 with tready held high: latency, throughput and done timing.
        mode = 0;
        @(negedge clk);
        build_job(0);
        start = 1'b1;
        img_idx = 7'd0;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        check("lat_mem_en", mem_en, 1);
        check("lat_busy", busy, 1);
        check("lat_valid_e0", tvalid, 0);
        @(negedge clk);
        check("lat_valid_e1", tvalid, 0);
        @(negedge clk);
        check("lat_valid_e2", tvalid, 1);
        wait_done(30000);
        check("job0_cycles", cyc - start_cyc, 24647);
        check("job0_busy_at_done", busy, 1);
        check("job0_handshakes", hs, JOB_LEN);
        check("job0_tlasts", last_cnt, EXP_LASTS);
        check("job0_leftover", exp_data_q.size(), 0);
        @(negedge clk);
        check("job0_done_pulse", done, 0);
        check("job0_busy_after", busy, 0);

        // Out-of-range image request.
        @(negedge clk);
        start = 1'b1;
        img_idx = 7'd100;
        @(negedge clk);
        start = 1'b0;
        check("bad_err", err, 1);
        check("bad_busy", busy, 0);
        check("bad_mem_en", mem_en, 0);
        @(negedge clk);
        check("bad_err_pulse", err, 0);
        check("bad_mem_en2", mem_en, 0);
        check("bad_busy2", busy, 0);

        // Image 5, then stall at word 10000 and reset mid-job.
        @(negedge clk);
        build_job(5);
        start = 1'b1;
        img_idx = 7'd5;
        @(negedge clk);
        start = 1'b0;
        check("img5_addr", mem_addr, 3920);
        wait_hs(10000, 12000);
        mode = 2;
        repeat (8) @(negedge clk);
        check("stalled_valid", tvalid, 1);
        check("stalled_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tvalid", tvalid, 0);
        check("abort_busy", busy, 0);
        check("abort_mem_en", mem_en, 0);
        check("abort_mem_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b0;

        // Image 99 with random tready, plus an ignored start mid-job.
        mode = 1;
        @(negedge clk);
        build_job(99);
        start = 1'b1;
        img_idx = 7'd99;
        @(negedge clk);
        start = 1'b0;
        check("img99_addr", mem_addr, 77616);
        wait_hs(3000, 20000);
        mode = 0;
        wait_hs(5000, 10000);
        @(negedge clk);
        start = 1'b1;
        img_idx = 7'd3;
        @(negedge clk);
        start = 1'b0;
        check("midjob_err", err, 0);
        check("midjob_busy", busy, 1);
        wait_done(40000);
        check("job99_handshakes", hs, JOB_LEN);
        check("job99_tlasts", last_cnt, EXP_LASTS);
        check("job99_leftover", exp_data_q.size(), 0);
        @(negedge clk);
        check("job99_busy_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlp_param_streamer.md
# mlp_param_streamer

AXI-Stream master that feeds the `axi_mlp_v1_0` S_AXIS slave with one complete classification job.
- Reads 18-bit fixed-point words from a single-port parameter BRAM.
- Emits them in the exact order the MLP core consumes: 784 image pixels, then 30 hidden neurons of (784 weights + 1 bias), then 10 output neurons of (30 weights + 1 bias).
- Sits between the parameter memory (PS-loaded) and the MLP IP.
- Replaces software-driven streaming of 24 644 words per image.

## Interface
Parameters:
- ADDR_W, 17, BRAM word-address width
- NUM_IMAGES, 100, images stored in the image region
- IMG_BASE, 0, first pixel address of image 0
- W1_BASE, 78400, hidden weights, neuron-major, 784 per neuron
- B1_BASE, 101920, hidden biases, 30 words
- W2_BASE, 101950, output weights, neuron-major, 30 per neuron
- B2_BASE, 102250, output biases, 10 words
- FIFO_DEPTH, 4, output buffer depth (minimum 4)

Ports:
- clk  in  1  single clock for the whole block
- reset  in  1  synchronous, active-high
- start  in  1  job request, sampled only in IDLE
- img_idx  in  7  image number
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after the last word handshakes
- err  out  1  one-cycle pulse when start is rejected
- mem_en  out  1  BRAM read enable (registered)
- mem_addr  out  ADDR_W  BRAM read address (registered)
- mem_rdata  in  18  BRAM data, valid one cycle after mem_en
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tdata  out  32  {14'b0, word}, zero-extended
- m_axis_tstrb  out  4  4'b1111 while tvalid, else 4'b0000
- m_axis_tlast  out  1  segment end (see Configuration)

## Operation
- FSM states and transitions:
  - IDLE → IMG on a valid start.
  - IMG (784 reads from IMG_BASE + img_idx·784) → W1.
  - W1 (784 reads) → B1 (1 read) → W1, repeated until neuron 29 → W2.
  - W2 (30 reads) → B2 (1 read) → W2, repeated until neuron 9 → DRAIN.
  - DRAIN (wait until the FIFO is empty and no read is in flight) → IDLE, with done asserted for one cycle.
- Counters:
  - word counter i, 0..783 or 0..29.
  - neuron counter n, 0..29 or 0..9.
- Address generation:
  - W1: W1_BASE + n·784 + i.
  - B1: B1_BASE + n.
  - W2: W2_BASE + n·30 + i.
  - B2: B2_BASE + n.
  - Computed incrementally with a running pointer; no multiplier except the img_idx·784 term at start.
- Flow control is credit-based:
  - A read issues only when FIFO occupancy + reads in flight < FIFO_DEPTH.
  - The FIFO never overflows, and a BRAM read is never dropped.
- Reject rules:
  - start with img_idx ≥ NUM_IMAGES: err pulse, state stays IDLE.
  - start while busy: ignored, no err.
- busy is high from the cycle after start is accepted until the cycle done pulses, inclusive.
- Every word is emitted exactly once, in order, with no gaps or duplicates: 24 644 handshakes per job.

## Timing
- Reset values: busy=0, done=0, err=0, mem_en=0, mem_addr=0, m_axis_tvalid=0, tdata=0, tstrb=0, tlast=0. FSM goes to IDLE, FIFO is flushed, counters are cleared.
- Reset mid-job aborts immediately, with no further handshakes.
- Latency: start sampled at edge E0 → mem_en high after E0 → BRAM data after E1 → FIFO write at E2 → first tvalid after E2, i.e. 3 cycles after start.
- With tready held high, throughput is 1 word/cycle. Job length is 24 644 + 3 cycles, with done one cycle after the last handshake.
- AXIS rules:
  - tdata, tlast and tstrb stay stable while tvalid && !tready.
  - tvalid never drops without a handshake.
- FIFO behaviour:
  - Simultaneous push and pop keeps occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- tready low for any number of cycles stalls issue within FIFO_DEPTH reads.

## Configuration
- MLP_STREAMER_TLAST_EN defined:
  - tlast=1 on pixel 783.
  - tlast=1 on every bias word (B1 and B2).
  - tlast=0 otherwise.
- MLP_STREAMER_TLAST_EN undefined:
  - tlast is tied to 0.
  - The per-word segment flag is not stored in the FIFO, so FIFO width is 18 bits instead of 19.

## Structure
- Package `mlp_stream_pkg`:
  - state enum.
  - localparams IMG_LEN=784, HID_N=30, OUT_N=10, WORD_W=18.
  - JOB_WORDS=24644.
- One sub-module, `mlp_stream_fifo`:
  - synchronous FIFO, parameterised width and depth.
  - exports count for credit computation.

## Test plan
- Image 0, tready always 1, reference BRAM model:
  - Exactly 24 644 handshakes with the address sequence above.
  - Word 0 = mem[0], word 784 = mem[78400], word 1568 = mem[101920].
  - done 24 647 cycles after start.
- Image 99, random tready at 30 % duty:
  - Identical data order.
  - tdata stays stable under stall.
  - No lost or duplicated word.
  - FIFO occupancy never exceeds 4.
- start with img_idx=100 → err pulse, busy stays 0, no mem_en. Then start with img_idx=5 → first address 3920.
- Second start pulse mid-job:
  - Ignored, no err.
  - Handshake count stays 24 644.
- reset asserted at word 10 000 with tready=0:
  - Next cycle: tvalid=0, busy=0.
  - A new start then produces a clean job from pixel 0.
- With MLP_STREAMER_TLAST_EN defined:
  - tlast on words 783, 1568, …, 24 643 (41 pulses total).
  - Without the macro, tlast is never asserted.
